// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - byte receive stream and instruction memory write bus
interface prog_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_wen;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, imem_wen, imem_addr, imem_data
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, imem_wen, imem_addr, imem_data
  );
endinterface

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - framed byte-stream boot loader writing 16-bit words to instruction memory
module prog_loader #(
  parameter int MAX_WORDS = 256,
  parameter int TIMEOUT   = 50000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  prog_loader_if.slave bus,
  output logic         cpu_rst,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [1:0]   err_code,
  output logic [15:0]  words_loaded
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DAT_HI, S_DAT_LO, S_WRITE, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic          rx_ready_q, rx_ready_d;
  logic          imem_wen_q, imem_wen_d;
  logic [15:0]   imem_addr_q, imem_addr_d;
  logic [15:0]   imem_data_q, imem_data_d;
  logic          cpu_rst_q, cpu_rst_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [1:0]    err_code_q, err_code_d;
  logic [15:0]   words_q, words_d;
  logic [7:0]    len_hi_q, len_hi_d;
  logic [15:0]   len_q, len_d;
  logic [15:0]   idx_q, idx_d;
  logic [7:0]    hi_q, hi_d;
  logic [7:0]    sum_q, sum_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic          accept;
  logic          receiving;
  logic          fail;
  logic [1:0]    fail_code;
  logic [7:0]    chk_sum;
  logic [15:0]   frame_len;
  logic [15:0]   idx_inc;

  // rx_ready_q is only ever high in a receiving state, so this is the transfer condition
  assign accept    = bus.rx_valid & rx_ready_q;
  assign receiving = state_q inside {S_LEN_HI, S_LEN_LO, S_DAT_HI, S_DAT_LO, S_CHK};
  assign chk_sum   = sum_q + bus.rx_data;
  assign frame_len = {len_hi_q, bus.rx_data};
  assign idx_inc   = idx_q + 16'd1;

  always_comb begin
    state_d     = state_q;
    imem_wen_d  = 1'b0;
    imem_addr_d = imem_addr_q;
    imem_data_d = imem_data_q;
    cpu_rst_d   = cpu_rst_q;
    busy_d      = busy_q;
    done_d      = done_q;
    err_d       = err_q;
    err_code_d  = err_code_q;
    words_d     = words_q;
    len_hi_d    = len_hi_q;
    len_d       = len_q;
    idx_d       = idx_q;
    hi_d        = hi_q;
    sum_d       = sum_q;
    tmo_d       = tmo_q;
    fail        = 1'b0;
    fail_code   = 2'd0;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_LEN_HI;
          done_d     = 1'b0;
          err_d      = 1'b0;
          err_code_d = 2'd0;
          words_d    = 16'd0;
          sum_d      = 8'd0;
          idx_d      = 16'd0;
          tmo_d      = '0;
          cpu_rst_d  = 1'b1;
          busy_d     = 1'b1;
        end
      end
      S_LEN_HI: if (accept) begin
        len_hi_d = bus.rx_data;
        state_d  = S_LEN_LO;
      end
      S_LEN_LO: if (accept) begin
        len_d = frame_len;
        if ({1'b0, frame_len} > 17'(MAX_WORDS)) begin
          fail      = 1'b1;
          fail_code = 2'd1;
        end else if (frame_len == 16'd0) begin
          state_d = S_CHK;
        end else begin
          state_d = S_DAT_HI;
        end
      end
      S_DAT_HI: if (accept) begin
        hi_d    = bus.rx_data;
        state_d = S_DAT_LO;
      end
      S_DAT_LO: if (accept) begin
        imem_wen_d  = 1'b1;
        imem_addr_d = idx_q << 1;
        imem_data_d = {hi_q, bus.rx_data};
        state_d     = S_WRITE;
      end
      S_WRITE: begin
        idx_d   = idx_inc;
        words_d = words_q + 16'd1;
        state_d = (idx_inc == len_q) ? S_CHK : S_DAT_HI;
      end
      S_CHK: if (accept) begin
        if (chk_sum == 8'd0) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          cpu_rst_d = 1'b0;
        end else begin
          fail      = 1'b1;
          fail_code = 2'd2;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Running checksum and idle watchdog shared by every receiving state
    if (receiving) begin
      if (accept) begin
        sum_d = chk_sum;
        tmo_d = '0;
      end else if (tmo_q == TW'(TIMEOUT - 1)) begin
        fail      = 1'b1;
        fail_code = 2'd3;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end

    if (fail) begin
      state_d    = S_ERR;
      err_d      = 1'b1;
      err_code_d = fail_code;
      busy_d     = 1'b0;
      cpu_rst_d  = 1'b1;
    end

    rx_ready_d = state_d inside {S_LEN_HI, S_LEN_LO, S_DAT_HI, S_DAT_LO, S_CHK};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rx_ready_q  <= 1'b0;
      imem_wen_q  <= 1'b0;
      imem_addr_q <= 16'd0;
      imem_data_q <= 16'd0;
      cpu_rst_q   <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= 2'd0;
      words_q     <= 16'd0;
      len_hi_q    <= 8'd0;
      len_q       <= 16'd0;
      idx_q       <= 16'd0;
      hi_q        <= 8'd0;
      sum_q       <= 8'd0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      rx_ready_q  <= rx_ready_d;
      imem_wen_q  <= imem_wen_d;
      imem_addr_q <= imem_addr_d;
      imem_data_q <= imem_data_d;
      cpu_rst_q   <= cpu_rst_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      words_q     <= words_d;
      len_hi_q    <= len_hi_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      hi_q        <= hi_d;
      sum_q       <= sum_d;
      tmo_q       <= tmo_d;
    end
  end

  assign bus.rx_ready  = rx_ready_q;
  assign bus.imem_wen  = imem_wen_q;
  assign bus.imem_addr = imem_addr_q;
  assign bus.imem_data = imem_data_q;
  assign cpu_rst       = cpu_rst_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign err_code      = err_code_q;
  assign words_loaded  = words_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed self-checking bench for prog_loader
module tb_prog_loader;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        cpu_rst, busy, done, err;
  logic [1:0]  err_code;
  logic [15:0] words_loaded;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [15:0] wa[$];
  logic [15:0] wd[$];
  int          wc[$];

  localparam logic [55:0] RESET_VEC = {1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0};

  prog_loader_if bus ();

  prog_loader #(.MAX_WORDS(256), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err),
    .err_code(err_code), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.imem_wen === 1'b1) begin
      wa.push_back(bus.imem_addr);
      wd.push_back(bus.imem_data);
      wc.push_back(cyc);
    end
  end

  function automatic logic [55:0] out_vec();
    return {bus.rx_ready, bus.imem_wen, bus.imem_addr, bus.imem_data,
            cpu_rst, busy, done, err, err_code, words_loaded};
  endfunction

  task automatic clear_log();
    @(negedge clk);
    wa.delete(); wd.delete(); wc.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int n;
    int gap;
    gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
    bus.rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    n = 0;
    while (bus.rx_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n >= 64) begin
      n_fail++;
      $display("FAIL rx_wait: rx_ready stayed %b for byte %h, required 1 within 64 cycles", bus.rx_ready, b);
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_frame(input bq_t f, input int maxgap);
    foreach (f[i]) send_byte(f[i], maxgap);
  endtask

  task automatic load_good_image(input string tag, input int maxgap);
    bq_t f;
    f = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    clear_log();
    pulse_start();
    n_checks++;
    if ({busy, cpu_rst, done, err} !== 4'b1100) begin
      n_fail++; $display("FAIL %s_start: busy,cpu_rst,done,err=%b required 1100", tag, {busy, cpu_rst, done, err});
    end
    send_frame(f, maxgap);
    n_checks++;
    if (done !== 1'b1 || cpu_rst !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL %s_done: done=%b cpu_rst=%b err=%b busy=%b required 1 0 0 0", tag, done, cpu_rst, err, busy);
    end
    n_checks++;
    if (words_loaded !== 16'd2) begin
      n_fail++; $display("FAIL %s_words: got %0d required 2", tag, words_loaded);
    end
    n_checks++;
    if (wa.size() != 2) begin
      n_fail++; $display("FAIL %s_nwrites: got %0d required 2", tag, wa.size());
    end else begin
      n_checks++;
      if (wa[0] !== 16'h0000 || wd[0] !== 16'h1234) begin
        n_fail++; $display("FAIL %s_write0: got %h:%h required 0000:1234", tag, wa[0], wd[0]);
      end
      n_checks++;
      if (wa[1] !== 16'h0002 || wd[1] !== 16'hABCD) begin
        n_fail++; $display("FAIL %s_write1: got %h:%h required 0002:abcd", tag, wa[1], wd[1]);
      end
      if (maxgap == 0) begin
        n_checks++;
        if (wc[1] - wc[0] != 3) begin
          n_fail++; $display("FAIL %s_throughput: write spacing %0d cycles required 3", tag, wc[1] - wc[0]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    n_checks++;
    if (out_vec() !== RESET_VEC) begin
      n_fail++; $display("FAIL reset_values: got %h required %h", out_vec(), RESET_VEC);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_good();
    load_good_image("good", 0);
  endtask

  task automatic test_empty();
    bq_t f;
    f = '{8'h00, 8'h00, 8'h00};
    clear_log();
    pulse_start();
    send_frame(f, 0);
    n_checks++;
    if (done !== 1'b1 || words_loaded !== 16'd0 || cpu_rst !== 1'b0 || wa.size() != 0) begin
      n_fail++; $display("FAIL empty: done=%b words=%0d cpu_rst=%b writes=%0d required 1 0 0 0", done, words_loaded, cpu_rst, wa.size());
    end
  endtask

  task automatic test_len_big();
    bq_t f;
    f = '{8'h01, 8'h01};
    clear_log();
    pulse_start();
    send_frame(f, 0);
    n_checks++;
    if (err !== 1'b1 || err_code !== 2'd1 || cpu_rst !== 1'b1 || busy !== 1'b0 || bus.rx_ready !== 1'b0) begin
      n_fail++; $display("FAIL len_big: err=%b code=%0d cpu_rst=%b busy=%b rx_ready=%b required 1 1 1 0 0", err, err_code, cpu_rst, busy, bus.rx_ready);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (wa.size() != 0) begin
      n_fail++; $display("FAIL len_big_writes: got %0d required 0", wa.size());
    end
  endtask

  task automatic test_bad_chk();
    bq_t f;
    f = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
    clear_log();
    pulse_start();
    send_frame(f, 0);
    n_checks++;
    if (err !== 1'b1 || err_code !== 2'd2 || cpu_rst !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL bad_chk: err=%b code=%0d cpu_rst=%b done=%b required 1 2 1 0", err, err_code, cpu_rst, done);
    end
    n_checks++;
    if (wa.size() != 2 || words_loaded !== 16'd2) begin
      n_fail++; $display("FAIL bad_chk_writes: writes=%0d words=%0d required 2 2", wa.size(), words_loaded);
    end
  endtask

  task automatic test_timeout();
    bq_t f;
    f = '{8'h00, 8'h02, 8'h12};
    clear_log();
    pulse_start();
    send_frame(f, 0);
    repeat (15) @(negedge clk);
    n_checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL timeout_early: err=%b busy=%b after 15 idle cycles required 0 1", err, busy);
    end
    @(negedge clk);
    n_checks++;
    if (err !== 1'b1 || err_code !== 2'd3 || busy !== 1'b0 || cpu_rst !== 1'b1) begin
      n_fail++; $display("FAIL timeout: err=%b code=%0d busy=%b cpu_rst=%b after 16 idle cycles required 1 3 0 1", err, err_code, busy, cpu_rst);
    end
  endtask

  task automatic test_len_max();
    bq_t f;
    f = '{8'h01, 8'h00};
    clear_log();
    pulse_start();
    send_frame(f, 0);
    n_checks++;
    if (err !== 1'b0 || busy !== 1'b1 || bus.rx_ready !== 1'b1) begin
      n_fail++; $display("FAIL len_max: err=%b busy=%b rx_ready=%b required 0 1 1", err, busy, bus.rx_ready);
    end
    repeat (16) @(negedge clk);
    n_checks++;
    if (err !== 1'b1 || err_code !== 2'd3) begin
      n_fail++; $display("FAIL len_max_timeout: err=%b code=%0d required 1 3", err, err_code);
    end
  endtask

  task automatic test_back_to_back();
    bq_t f1, f2;
    f1 = '{8'h00, 8'h02, 8'h12};
    f2 = '{8'h34, 8'hAB, 8'hCD, 8'h40};
    clear_log();
    pulse_start();
    send_frame(f1, 0);
    pulse_start();
    send_frame(f2, 0);
    n_checks++;
    if (done !== 1'b1 || words_loaded !== 16'd2 || wa.size() != 2) begin
      n_fail++; $display("FAIL start_while_busy: done=%b words=%0d writes=%0d required 1 2 2", done, words_loaded, wa.size());
    end
    load_good_image("reload", 0);
  endtask

  task automatic test_reset_mid();
    bq_t f;
    f = '{8'h00, 8'h02, 8'h12};
    clear_log();
    pulse_start();
    send_frame(f, 3);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (out_vec() !== RESET_VEC) begin
      n_fail++; $display("FAIL reset_mid: got %h required %h", out_vec(), RESET_VEC);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    load_good_image("rst_follow", 3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_good();
    test_empty();
    test_len_big();
    test_bad_chk();
    test_timeout();
    test_len_max();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader that sits directly upstream of the CPU's instruction ROM. It receives a framed byte stream over a valid/ready byte interface, assembles big-endian 16-bit instruction words, and writes them to instruction memory at even byte addresses starting at 0x0000. It holds the CPU in reset for the whole load and releases it only after a length- and checksum-verified image has been written.

## Interface
Parameters:
- MAX_WORDS, 256: largest accepted image length, in 16-bit words.
- TIMEOUT, 50000: idle cycles allowed between accepted bytes before the load aborts.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader accepts a byte; a transfer occurs on a rising edge where rx_valid and rx_ready are both 1.
- imem_wen  out  1  instruction memory write strobe.
- imem_addr  out  16  byte address of the write; always even.
- imem_data  out  16  instruction word to write.
- cpu_rst  out  1  reset to the CPU core.
- busy  out  1  a load is in progress.
- done  out  1  the last load completed successfully.
- err  out  1  the last load aborted.
- err_code  out  2  abort cause: 0 none, 1 length > MAX_WORDS, 2 checksum mismatch, 3 timeout.
- words_loaded  out  16  number of words written in the current or last load.

## Operation
- Frame format: LEN_HI, LEN_LO, then LEN data words (each high byte first, then low byte), then one checksum byte CHK.
- Validity rule: the sum mod 256 of every frame byte, including the length bytes and CHK, must equal 0x00.
- FSM states: IDLE, LEN_HI, LEN_LO, DAT_HI, DAT_LO, WRITE, CHK, DONE, ERR.
- IDLE, DONE or ERR, on start: go to LEN_HI. Clear done, err, err_code, words_loaded, the running sum and the word index. Set cpu_rst=1 and busy=1.
- LEN_HI on accept: go to LEN_LO.
- LEN_LO on accept:
  - If {hi,lo} > MAX_WORDS: go to ERR with code 1.
  - Else if length = 0: go to CHK.
  - Else: go to DAT_HI.
- DAT_HI on accept: latch the high byte and go to DAT_LO.
- DAT_LO on accept: latch the low byte and go to WRITE.
- WRITE (exactly one cycle, rx_ready=0):
  - Drive imem_wen=1, imem_addr={index,1'b0}, imem_data={hi,lo}.
  - Increment index and words_loaded.
  - If index+1 = length: go to CHK. Else: go to DAT_HI.
- CHK on accept: if (sum + CHK) mod 256 = 0, go to DONE; else go to ERR with code 2.
- DONE: done=1, busy=0, cpu_rst=0.
- ERR: err=1, busy=0, cpu_rst=1.
- rx_ready is 1 only in LEN_HI, LEN_LO, DAT_HI, DAT_LO and CHK.
- Timeout counter:
  - Cleared on entering LEN_HI and on every accepted byte.
  - Increments every cycle spent in a receiving state without an accept.
  - Reaching TIMEOUT: go to ERR with code 3.
- start is ignored while busy=1.
- Memory already written before an ERR is not rolled back.
- rx_valid may drop at any point; the FSM waits with no other side effects except the timeout counter.

## Timing
- Reset values: state IDLE, rx_ready=0, imem_wen=0, imem_addr=0, imem_data=0, cpu_rst=1, busy=0, done=0, err=0, err_code=0, words_loaded=0.
- Reset asserted mid-load returns every output to its reset value immediately (asynchronously). No imem write completes after rst rises.
- All outputs are registered.
- rx_ready becomes 1 in the first cycle of a receiving state.
- imem_wen is high for exactly one cycle per word: the cycle after the low byte is accepted.
- Maximum throughput is one word per 3 cycles (DAT_HI, DAT_LO, WRITE) with rx_valid held high.
- done=1 and cpu_rst=0 appear in the cycle after the CHK byte is accepted.
- An ERR transition is visible the cycle after the offending accept, or the cycle after the timeout count is reached.
- start and an accept cannot coincide, because rx_ready=0 in IDLE, DONE and ERR.

## Test plan
- Good image, rx_valid held high:
  - Stimulus: start, then bytes 00 02 12 34 AB CD 40.
  - Required: writes (0x0000, 0x1234) and (0x0002, 0xABCD), each with a one-cycle imem_wen.
  - Required after the last byte: done=1, cpu_rst=0, words_loaded=2, err=0.
- Empty image: bytes 00 00 00 -> no imem_wen pulses, done=1, words_loaded=0.
- Length too large (MAX_WORDS=256): bytes 01 01 -> err=1, err_code=1, cpu_rst=1, no writes.
- Bad checksum: bytes 00 02 12 34 AB CD 41 -> both words written, then err=1, err_code=2, cpu_rst stays 1.
- Timeout (bench TIMEOUT=16): bytes 00 02 12, then rx_valid=0 -> err_code=3 exactly after 16 idle cycles.
- Reset mid-load, with random rx_valid gaps:
  - Stimulus: assert rst after byte 12.
  - Required: all outputs at reset values.
  - Follow-up: start plus the good image -> identical result to the first scenario.
